// File: rtl/mem_port_arb_pkg.sv
// Shared types for the memory-port arbiter: FSM states, owner tag,
// latched request record and the fetch-word select helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [63:0] wdata;
    logic [7:0]  wmask;
  } req_t;

  // Fetches always go out on an 8-byte boundary.
  localparam logic [31:0] IFU_ALIGN_MASK = 32'hFFFF_FFF8;

  // Pick the 32-bit instruction word out of a 64-bit beat.
  function automatic logic [31:0] sel_word(input logic [63:0] data, input logic hi);
    return hi ? data[63:32] : data[31:0];
  endfunction

endpackage

// File: rtl/mem_port_arb_if.sv
// Bundle of the fetch, load/store and downstream memory handshakes.
// slave  = arbiter view, master = view of the requesters plus memory.
interface mem_port_arb_if;

  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_resp_valid;
  logic [31:0] ifu_rdata;

  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [63:0] lsu_wdata;
  logic [7:0]  lsu_wmask;
  logic        lsu_resp_valid;
  logic [63:0] lsu_rdata;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [63:0] mem_rdata;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata
  );

endinterface

// File: rtl/mem_port_arb_prio_starve.sv
// Grant selection for the shared memory port: load/store wins by default,
// but after STARVE_LIMIT back-to-back LSU grants with a fetch waiting the
// next grant goes to the fetch unit.
module arb_prio_starve #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic idle,
  input  logic ifu_valid,
  input  logic lsu_valid,
  output logic grant_ifu,
  output logic grant_lsu
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             force_ifu;

  // Grants only while running and idle; reset holds both ready lines low.
  always_comb begin
    force_ifu = ifu_valid && (starve_cnt == LIMIT);
    grant_ifu = rst && idle && ifu_valid && (!lsu_valid || force_ifu);
    grant_lsu = rst && idle && lsu_valid && !force_ifu;
  end

  // Count LSU grants that bypassed a waiting fetch; any fetch grant or an
  // uncontended LSU grant restarts the count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (grant_ifu) begin
      starve_cnt <= '0;
    end else if (grant_lsu) begin
      if (!ifu_valid)
        starve_cnt <= '0;
      else if (starve_cnt < LIMIT)
        starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arb.sv
// Single-outstanding arbiter for the one physical memory port shared by
// instruction fetch (read-only) and load/store.
module mem_port_arb
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic           clk,
  input  logic           rst,
  mem_port_arb_if.slave  bus
);

  state_t      state;
  owner_t      owner;
  req_t        req;
  logic        addr_hi;
  logic        mem_req_valid_q;
  logic        ifu_resp_q;
  logic        lsu_resp_q;
  logic [63:0] rdata_q;
  logic        grant_ifu;
  logic        grant_lsu;

  arb_prio_starve #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_prio (
    .clk       (clk),
    .rst       (rst),
    .idle      (state == IDLE),
    .ifu_valid (bus.ifu_req_valid),
    .lsu_valid (bus.lsu_req_valid),
    .grant_ifu (grant_ifu),
    .grant_lsu (grant_lsu)
  );

  assign bus.ifu_req_ready  = grant_ifu;
  assign bus.lsu_req_ready  = grant_lsu;
  assign bus.mem_req_valid  = mem_req_valid_q;
  assign bus.mem_addr       = req.addr;
  assign bus.mem_wen        = req.wen;
  assign bus.mem_wdata      = req.wdata;
  assign bus.mem_wmask      = req.wmask;
  assign bus.ifu_resp_valid = ifu_resp_q;
  assign bus.lsu_resp_valid = lsu_resp_q;
  assign bus.ifu_rdata      = sel_word(rdata_q, addr_hi);
  assign bus.lsu_rdata      = rdata_q;

  // Transaction FSM: latch the winner, issue downstream, wait for the
  // response, then pulse the owner's resp_valid for one cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= IDLE;
      owner           <= OWN_IFU;
      req             <= '0;
      addr_hi         <= 1'b0;
      mem_req_valid_q <= 1'b0;
      ifu_resp_q      <= 1'b0;
      lsu_resp_q      <= 1'b0;
      rdata_q         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_lsu) begin
            owner           <= OWN_LSU;
            req             <= '{addr:  bus.lsu_addr,
                                 wen:   bus.lsu_wen,
                                 wdata: bus.lsu_wdata,
                                 wmask: bus.lsu_wmask};
            mem_req_valid_q <= 1'b1;
            state           <= ISSUE;
          end else if (grant_ifu) begin
            owner           <= OWN_IFU;
            req             <= '{addr:  bus.ifu_addr & IFU_ALIGN_MASK,
                                 wen:   1'b0,
                                 wdata: 64'd0,
                                 wmask: 8'd0};
            addr_hi         <= bus.ifu_addr[2];
            mem_req_valid_q <= 1'b1;
            state           <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            if (bus.mem_resp_valid) begin
              rdata_q    <= bus.mem_rdata;
              ifu_resp_q <= (owner == OWN_IFU);
              lsu_resp_q <= (owner == OWN_LSU);
              state      <= RESP;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (bus.mem_resp_valid) begin
            rdata_q    <= bus.mem_rdata;
            ifu_resp_q <= (owner == OWN_IFU);
            lsu_resp_q <= (owner == OWN_LSU);
            state      <= RESP;
          end
        end
        RESP: begin
          ifu_resp_q <= 1'b0;
          lsu_resp_q <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb: a table of single transactions plus
// hand-written sequences for contention, starvation and reset mid-WAIT.
module tb_mem_port_arb;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  mem_port_arb_if bus ();

  mem_port_arb #(
    .STARVE_LIMIT (4),
    .CNT_W        (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        is_lsu;
    logic [31:0] addr;
    logic        wen;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] rdata;
    int          stall;
    int          delay;
    logic [31:0] exp_addr;
    logic [63:0] exp_rdata;
  } vec_t;

  vec_t vecs [5];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".ifu_ready"},  64'(bus.ifu_req_ready),  64'd0);
    check({tag, ".lsu_ready"},  64'(bus.lsu_req_ready),  64'd0);
    check({tag, ".ifu_resp"},   64'(bus.ifu_resp_valid), 64'd0);
    check({tag, ".lsu_resp"},   64'(bus.lsu_resp_valid), 64'd0);
    check({tag, ".mem_valid"},  64'(bus.mem_req_valid),  64'd0);
    check({tag, ".mem_addr"},   64'(bus.mem_addr),       64'd0);
    check({tag, ".mem_wen"},    64'(bus.mem_wen),        64'd0);
    check({tag, ".mem_wdata"},  bus.mem_wdata,           64'd0);
    check({tag, ".mem_wmask"},  64'(bus.mem_wmask),      64'd0);
    check({tag, ".lsu_rdata"},  bus.lsu_rdata,           64'd0);
    check({tag, ".ifu_rdata"},  64'(bus.ifu_rdata),      64'd0);
  endtask

  task automatic check_issue(input vec_t v, input string tag);
    check({tag, ".mem_valid"}, 64'(bus.mem_req_valid), 64'd1);
    check({tag, ".mem_addr"},  64'(bus.mem_addr),      64'(v.exp_addr));
    check({tag, ".mem_wen"},   64'(bus.mem_wen),       64'(v.is_lsu & v.wen));
    check({tag, ".mem_wmask"}, 64'(bus.mem_wmask),     64'(v.is_lsu ? v.wmask : 8'd0));
    if (v.is_lsu)
      check({tag, ".mem_wdata"}, bus.mem_wdata, v.wdata);
  endtask

  // One complete transaction from a single requester.
  task automatic run_txn(input vec_t v, input string tag);
    @(negedge clk);
    if (v.is_lsu) begin
      bus.lsu_req_valid = 1'b1;
      bus.lsu_addr      = v.addr;
      bus.lsu_wen       = v.wen;
      bus.lsu_wdata     = v.wdata;
      bus.lsu_wmask     = v.wmask;
    end else begin
      bus.ifu_req_valid = 1'b1;
      bus.ifu_addr      = v.addr;
    end
    #1;
    check({tag, ".grant"},
          64'(v.is_lsu ? bus.lsu_req_ready : bus.ifu_req_ready), 64'd1);
    check({tag, ".other_ready"},
          64'(v.is_lsu ? bus.ifu_req_ready : bus.lsu_req_ready), 64'd0);
    @(negedge clk);
    bus.ifu_req_valid = 1'b0;
    bus.lsu_req_valid = 1'b0;
    bus.mem_rdata     = v.rdata;
    for (int s = 0; s < v.stall; s++) begin
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b0;
      #1;
      check_issue(v, {tag, ".stall"});
      check({tag, ".stall_resp"}, 64'(bus.ifu_resp_valid | bus.lsu_resp_valid), 64'd0);
      @(negedge clk);
    end
    bus.mem_req_ready  = 1'b1;
    bus.mem_resp_valid = (v.delay == 0);
    #1;
    check_issue(v, {tag, ".issue"});
    for (int d = 1; d <= v.delay; d++) begin
      @(negedge clk);
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = (d == v.delay);
      #1;
      check({tag, ".wait_valid"}, 64'(bus.mem_req_valid), 64'd0);
      check({tag, ".wait_resp"}, 64'(bus.ifu_resp_valid | bus.lsu_resp_valid), 64'd0);
    end
    @(negedge clk);
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    #1;
    check({tag, ".resp"},
          64'(v.is_lsu ? bus.lsu_resp_valid : bus.ifu_resp_valid), 64'd1);
    check({tag, ".nonowner_resp"},
          64'(v.is_lsu ? bus.ifu_resp_valid : bus.lsu_resp_valid), 64'd0);
    check({tag, ".rdata"},
          v.is_lsu ? bus.lsu_rdata : {32'd0, bus.ifu_rdata}, v.exp_rdata);
    @(negedge clk);
    #1;
    check({tag, ".pulse_end"}, 64'(bus.ifu_resp_valid | bus.lsu_resp_valid), 64'd0);
    check({tag, ".idle_valid"}, 64'(bus.mem_req_valid), 64'd0);
  endtask

  initial begin
    logic exp_lsu [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int   grants;
    int   cyc;

    //                 lsu   addr          wen   wdata                  wmask  rdata                  stl dly exp_addr      exp_rdata
    vecs[0] = '{1'b0, 32'h8000_0004, 1'b0, 64'd0,                 8'h00, 64'h1111_2222_3333_4444, 0, 1, 32'h8000_0000, 64'h0000_0000_1111_2222};
    vecs[1] = '{1'b0, 32'h8000_0013, 1'b0, 64'd0,                 8'h00, 64'hAAAA_BBBB_CCCC_DDDD, 0, 0, 32'h8000_0010, 64'h0000_0000_CCCC_DDDD};
    vecs[2] = '{1'b1, 32'h8000_0123, 1'b0, 64'h0123_4567_89AB_CDEF, 8'h0F, 64'h5555_6666_7777_8888, 0, 2, 32'h8000_0123, 64'h5555_6666_7777_8888};
    vecs[3] = '{1'b1, 32'h8000_1000, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 64'h0000_0000_0000_0000, 5, 0, 32'h8000_1000, 64'h0000_0000_0000_0000};
    vecs[4] = '{1'b0, 32'h8000_000C, 1'b0, 64'd0,                 8'h00, 64'h0F0F_0F0F_F0F0_F0F0, 5, 1, 32'h8000_0008, 64'h0000_0000_0F0F_0F0F};

    bus.ifu_req_valid  = 1'b1;
    bus.ifu_addr       = 32'h8000_0040;
    bus.lsu_req_valid  = 1'b1;
    bus.lsu_addr       = 32'h8000_2000;
    bus.lsu_wen        = 1'b1;
    bus.lsu_wdata      = 64'h1234_5678_9ABC_DEF0;
    bus.lsu_wmask      = 8'hFF;
    bus.mem_req_ready  = 1'b1;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 64'hFFFF_FFFF_FFFF_FFFF;

    // Reset with every input active: nothing may be granted or issued.
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    bus.ifu_req_valid  = 1'b0;
    bus.lsu_req_valid  = 1'b0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    rst = 1'b1;

    for (int i = 0; i < 5; i++)
      run_txn(vecs[i], $sformatf("vec%0d", i));

    // Simultaneous requests: LSU store first, fetch right after RESP.
    @(negedge clk);
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_0020;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 32'h8000_1000;
    bus.lsu_wen       = 1'b1;
    bus.lsu_wdata     = 64'hDEAD_BEEF_CAFE_F00D;
    bus.lsu_wmask     = 8'hFF;
    #1;
    check("sim.lsu_ready", 64'(bus.lsu_req_ready), 64'd1);
    check("sim.ifu_ready", 64'(bus.ifu_req_ready), 64'd0);
    @(negedge clk);
    bus.lsu_req_valid  = 1'b0;
    bus.mem_req_ready  = 1'b1;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 64'h0000_0001_0000_0002;
    #1;
    check("sim.mem_wen", 64'(bus.mem_wen), 64'd1);
    check("sim.mem_addr", 64'(bus.mem_addr), 64'h8000_1000);
    check("sim.ifu_wait_issue", 64'(bus.ifu_req_ready), 64'd0);
    @(negedge clk);
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    #1;
    check("sim.lsu_resp", 64'(bus.lsu_resp_valid), 64'd1);
    check("sim.ifu_wait_resp", 64'(bus.ifu_req_ready), 64'd0);
    @(negedge clk);
    #1;
    check("sim.ifu_grant", 64'(bus.ifu_req_ready), 64'd1);
    @(negedge clk);
    bus.ifu_req_valid  = 1'b0;
    bus.mem_req_ready  = 1'b1;
    bus.mem_resp_valid = 1'b1;
    #1;
    check("sim.ifu_addr", 64'(bus.mem_addr), 64'h8000_0020);
    check("sim.ifu_wen", 64'(bus.mem_wen), 64'd0);
    @(negedge clk);
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    #1;
    check("sim.ifu_resp", 64'(bus.ifu_resp_valid), 64'd1);
    check("sim.ifu_rdata", 64'(bus.ifu_rdata), 64'h0000_0002);

    // Starvation guard: both requesters held valid for ten grants.
    @(negedge clk);
    bus.ifu_req_valid  = 1'b1;
    bus.ifu_addr       = 32'h8000_0100;
    bus.lsu_req_valid  = 1'b1;
    bus.lsu_addr       = 32'h8000_3000;
    bus.lsu_wen        = 1'b0;
    bus.mem_req_ready  = 1'b1;
    bus.mem_resp_valid = 1'b1;
    grants = 0;
    cyc    = 0;
    while (grants < 10 && cyc < 60) begin
      #1;
      if (bus.ifu_req_ready || bus.lsu_req_ready) begin
        check($sformatf("starve.g%0d_lsu", grants), 64'(bus.lsu_req_ready), 64'(exp_lsu[grants]));
        check($sformatf("starve.g%0d_ifu", grants), 64'(bus.ifu_req_ready), 64'(!exp_lsu[grants]));
        grants++;
      end
      @(negedge clk);
      cyc++;
    end
    check("starve.grant_count", 64'(grants), 64'd10);
    bus.ifu_req_valid = 1'b0;
    bus.lsu_req_valid = 1'b0;
    repeat (3) @(negedge clk);
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;

    // Reset while in WAIT, then a stray response.
    @(negedge clk);
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 32'h8000_4000;
    bus.lsu_wen       = 1'b1;
    bus.lsu_wdata     = 64'h7777_7777_7777_7777;
    bus.lsu_wmask     = 8'h3C;
    @(negedge clk);
    bus.lsu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 64'h9999_8888_7777_6666;
    #1;
    check_all_zero("rstwait");
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    #1;
    check("rstwait.stray_lsu_resp", 64'(bus.lsu_resp_valid), 64'd0);
    check("rstwait.stray_rdata", bus.lsu_rdata, 64'd0);
    check("rstwait.mem_valid", 64'(bus.mem_req_valid), 64'd0);
    run_txn(vecs[0], "after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop in case a sequence wedges.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
